pipe_stage_reg: RTL and testbench

Generalised pipeline stage register for the RV32I pipeline. It replaces the fixed, always-enabled inter-stage registers with one parameterised block that has a valid/ready handshake, stall (backpressure), flush, and an optional skid entry. Payload is split into a control field and a data field:
- control holds write enables and source selects, and is forced to zero whenever the stage is empty or flushed, so a bubble can never commit state;
- data holds PC, ALU result, memory data, rd, and so on.

---
 rtl/pipe_stage_reg.sv | 179 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generalised inter-stage register for the RV32I pipeline. One payload slot
// ("main") drives the downstream outputs straight from flops; an optional
// second slot ("skid") absorbs one extra payload so that s_ready can come from
// a flop instead of from the downstream m_ready.
//
// The payload is split into two fields:
//   - control (write enables, source selects). It is forced to zero whenever
//     the main slot is empty, so a bubble can never commit architectural state.
//   - data (PC, ALU result, memory data, rd, ...). It has no meaning while the
//     slot is empty and is left stale.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream: s_valid/s_ready. Downstream: m_valid/m_ready. A valid
// payload is never withdrawn by this stage except by flush or reset.
//
// Parameters
//   DATA_W  width of the data payload
//   CTRL_W  width of the control payload
//   SKID    1: two entries, s_ready taken directly from a flop
//           0: one entry, s_ready = !m_valid || m_ready (combinational)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    upstream has a payload
//   s_ready    stage can accept a payload this cycle
//   s_ctrl     upstream control payload
//   s_data     upstream data payload
//   flush      synchronous kill of every held entry (highest priority)
//   m_valid    stage output holds a payload
//   m_ready    downstream consumes the payload this cycle
//   m_ctrl     output control payload, zero whenever m_valid is low
//   m_data     output data payload
//   occupancy  number of held entries (0..2, at most 1 when SKID=0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CTRL_W-1:0] s_ctrl,
  input  logic [DATA_W-1:0] s_data,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occupancy
);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;

  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic issue;

  // ---------------------------------------------------------------------------
  // Upstream ready
  // ---------------------------------------------------------------------------
  // In skid mode the stage can always take one more payload unless the skid
  // slot is already occupied, so s_ready depends on nothing but a flop.
  // In single-entry mode the slot frees up in the same cycle it is consumed.
  always_comb begin
    if (SKID != 0) begin
      s_ready = !skid_valid_q;
    end else begin
      s_ready = !main_valid_q || m_ready;
    end
  end

  assign accept = s_valid && s_ready;
  assign issue  = main_valid_q && m_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Default: every slot holds its contents.
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Everything held is dropped, including a payload accepted this cycle.
      // The data fields are left stale on purpose.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (skid_valid_q) begin
        // Skid is full, so s_ready is low and no accept can occur here.
        // The skid payload is older than anything upstream, so it moves
        // into main as soon as main drains.
        if (m_ready) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end
      end else if (!main_valid_q || m_ready) begin
        // Main is empty or being consumed: refill it from upstream, or
        // leave a bubble with its control field cleared.
        if (accept) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = s_ctrl;
          main_data_d  = s_data;
        end else begin
          main_valid_d = 1'b0;
          main_ctrl_d  = '0;
        end
      end else if (accept) begin
        // Main is stalled and skid was empty: park the new payload in skid.
        // s_ready drops on the following cycle.
        skid_valid_d = 1'b1;
        skid_ctrl_d  = s_ctrl;
        skid_data_d  = s_data;
      end
    end else begin
      // Single-entry mode. Accept is only possible when main is empty or
      // being consumed, so loading on accept also covers the swap case.
      if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = s_ctrl;
        main_data_d  = s_data;
      end else if (issue) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_valid   = main_valid_q;
  assign m_ctrl    = main_ctrl_q;
  assign m_data    = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives one shared input stream into two instances of pipe_stage_reg, one in
// skid mode and one in single-entry mode. Each instance has its own reference
// model: a FIFO queue with capacity 2 (skid) or 1 (single-entry). A compare
// process checks every output of both instances on each falling edge; the
// directed sequence also checks hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int ENT_W  = CTRL_W + DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic              s_valid = 1'b0;
  logic [CTRL_W-1:0] s_ctrl  = '0;
  logic [DATA_W-1:0] s_data  = '0;
  logic              m_ready = 1'b0;
  logic              flush   = 1'b0;

  // Skid-mode instance outputs
  logic              s_ready1, m_valid1;
  logic [CTRL_W-1:0] m_ctrl1;
  logic [DATA_W-1:0] m_data1;
  logic [1:0]        occ1;

  // Single-entry instance outputs
  logic              s_ready0, m_valid0;
  logic [CTRL_W-1:0] m_ctrl0;
  logic [DATA_W-1:0] m_data0;
  logic [1:0]        occ0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready1),
    .s_ctrl    (s_ctrl),
    .s_data    (s_data),
    .flush     (flush),
    .m_valid   (m_valid1),
    .m_ready   (m_ready),
    .m_ctrl    (m_ctrl1),
    .m_data    (m_data1),
    .occupancy (occ1)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready0),
    .s_ctrl    (s_ctrl),
    .s_data    (s_data),
    .flush     (flush),
    .m_valid   (m_valid0),
    .m_ready   (m_ready),
    .m_ctrl    (m_ctrl0),
    .m_data    (m_data0),
    .occupancy (occ0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: payloads in arrival order, {ctrl, data}
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] exp_q1[$];  // skid mode, capacity 2
  logic [ENT_W-1:0] exp_q0[$];  // single-entry mode, capacity 1
  bit acc1, iss1, acc0, iss0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      acc1 = s_valid && (exp_q1.size() < 2);
      iss1 = (exp_q1.size() > 0) && m_ready;
      acc0 = s_valid && ((exp_q0.size() == 0) || m_ready);
      iss0 = (exp_q0.size() > 0) && m_ready;
      if (flush) begin
        exp_q1.delete();
        exp_q0.delete();
      end else begin
        if (iss1) void'(exp_q1.pop_front());
        if (acc1) exp_q1.push_back({s_ctrl, s_data});
        if (iss0) void'(exp_q0.pop_front());
        if (acc0) exp_q0.push_back({s_ctrl, s_data});
      end
    end
  end

  // Compare process: every falling edge, both instances against their model.
  always @(negedge clk) begin
    chk("skid m_valid", m_valid1, exp_q1.size() > 0);
    chk("skid occupancy", occ1, exp_q1.size());
    chk("skid s_ready", s_ready1, exp_q1.size() < 2);
    chk("skid m_ctrl", m_ctrl1, exp_q1.size() > 0 ? exp_q1[0][ENT_W-1:DATA_W] : '0);
    if (exp_q1.size() > 0) chk("skid m_data", m_data1, exp_q1[0][DATA_W-1:0]);

    chk("single m_valid", m_valid0, exp_q0.size() > 0);
    chk("single occupancy", occ0, exp_q0.size());
    chk("single s_ready", s_ready0, (exp_q0.size() == 0) || m_ready);
    chk("single m_ctrl", m_ctrl0, exp_q0.size() > 0 ? exp_q0[0][ENT_W-1:DATA_W] : '0);
    if (exp_q0.size() > 0) chk("single m_data", m_data0, exp_q0[0][DATA_W-1:0]);
  end

  // ---------------------------------------------------------------------------
  // Driver: set inputs just after an edge, hold them through the next edge
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                      input logic [DATA_W-1:0] d, input logic mr, input logic fl);
    s_valid = v;
    s_ctrl  = c;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held with a valid payload presented upstream.
    s_valid = 1'b1;
    s_ctrl  = 8'h05;
    s_data  = 64'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("reset m_valid", m_valid1, 0);
    chk("reset m_ctrl", m_ctrl1, 0);
    chk("reset m_data", m_data1, 0);
    chk("reset occupancy", occ1, 0);
    chk("reset s_ready skid", s_ready1, 1);
    chk("reset s_ready single", s_ready0, 1);
    chk("reset m_data single", m_data0, 0);

    // First accept after release appears one edge later.
    rst_n = 1'b1;
    step(1, 8'h05, 64'hAA, 0, 0);
    chk("first accept valid", m_valid1, 1);
    chk("first accept data", m_data1, 64'hAA);
    chk("first accept ctrl", m_ctrl1, 8'h05);

    // Streaming, one payload per cycle in both modes.
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'h05, 64'(i), 1, 0);
      chk("stream data skid", m_data1, 64'(i));
      chk("stream data single", m_data0, 64'(i));
      chk("stream occupancy", occ1, 1);
    end
    step(0, 8'h00, 64'h0, 1, 0);
    chk("drain empty", m_valid1, 0);

    // Backpressure: A in main, stall, send B.
    step(1, 8'h03, 64'h10, 0, 0);
    chk("single s_ready stalled", s_ready0, 0);
    step(1, 8'h03, 64'h20, 0, 0);
    chk("bp occupancy 2", occ1, 2);
    chk("bp s_ready low", s_ready1, 0);
    chk("bp main holds A", m_data1, 64'h10);
    chk("single keeps A", m_data0, 64'h10);
    step(0, 8'h00, 64'h0, 1, 0);
    chk("bp B moves up", m_data1, 64'h20);
    chk("bp s_ready back", s_ready1, 1);
    step(0, 8'h00, 64'h0, 1, 0);
    chk("bp drained", occ1, 0);

    // Single-entry swap with no bubble.
    step(1, 8'h07, 64'h40, 0, 0);
    step(1, 8'h07, 64'h41, 1, 0);
    chk("swap valid", m_valid0, 1);
    chk("swap data", m_data0, 64'h41);
    step(0, 8'h00, 64'h0, 1, 0);

    // Flush with both entries full and a new payload offered.
    step(1, 8'hFF, 64'h50, 0, 0);
    step(1, 8'hFF, 64'h51, 0, 0);
    chk("pre-flush occupancy", occ1, 2);
    step(1, 8'hFF, 64'h30, 0, 1);
    chk("flush m_valid", m_valid1, 0);
    chk("flush m_ctrl", m_ctrl1, 0);
    chk("flush occupancy", occ1, 0);
    chk("flush s_ready", s_ready1, 1);
    chk("flush single", m_valid0, 0);
    step(0, 8'h00, 64'h0, 1, 0);
    chk("flushed stays empty", m_valid1, 0);

    // Flush coinciding with an issue.
    step(1, 8'h01, 64'h60, 1, 0);
    step(1, 8'h01, 64'h61, 1, 1);
    chk("flush+issue occupancy", occ1, 0);

    // Reset in the middle of a stall.
    step(1, 8'h02, 64'h70, 0, 0);
    step(1, 8'h02, 64'h71, 0, 0);
    chk("pre-reset occupancy", occ1, 2);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midreset m_valid", m_valid1, 0);
    chk("midreset m_ctrl", m_ctrl1, 0);
    chk("midreset m_data", m_data1, 0);
    chk("midreset occupancy", occ1, 0);
    chk("midreset s_ready", s_ready1, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 8'h00, 64'h0, 1, 0);
    step(0, 8'h00, 64'h0, 1, 0);
    chk("post-reset empty", m_valid1, 0);
    step(1, 8'h03, 64'h80, 1, 0);
    chk("post-reset accept", m_data1, 64'h80);

    // Random traffic, checked by the model alone.
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end
    step(0, 8'h00, 64'h0, 1, 0);
    step(0, 8'h00, 64'h0, 1, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
